// File: rtl/scan_chain_responder_pkg.sv
// Shared types and defaults for the scan chain responder.
package scan_resp_pkg;

    localparam int WIDTH_DEF      = 6;
    localparam int SEL_W          = 5;
    localparam int NUM_CHAINS_DEF = 22;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Selects are unsigned, so everything at or above num_chains is out of range.
    function automatic logic sel_valid(input logic [SEL_W-1:0] sel, input int num_chains);
        return (int'(sel) < num_chains);
    endfunction

endpackage

// File: rtl/scan_chain_responder_if.sv
// Tester-side bundle: pattern/select/strobe toward the responder, echo and status back.
interface scan_chain_responder_if
    import scan_resp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             test_clock;
    logic [WIDTH-1:0] K;
    logic [SEL_W-1:0] mux_decoder_input;
    logic             reset;
    logic [WIDTH-1:0] chain_input;
    logic [WIDTH-1:0] chain_output;
    logic             resp_valid;
    logic             overrun;
    logic [CNT_W-1:0] resp_count;

    modport master (
        output test_clock, K, mux_decoder_input, reset,
        input  chain_input, chain_output, resp_valid, overrun, resp_count
    );

    modport slave (
        input  test_clock, K, mux_decoder_input, reset,
        output chain_input, chain_output, resp_valid, overrun, resp_count
    );

endinterface

// File: rtl/scan_chain_responder_edge_sync.sv
// Two-flop synchronizer with a third flop for a one-cycle rising-edge pulse.
module edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_sync3;

endmodule

// File: rtl/scan_chain_responder.sv
// Emulated scan-chain DUT: serially loads the tester's pattern into a selected chain and echoes it back.
// Optional stuck-at fault on one chain's response is enabled by defining FAULT_INJECT_EN.
//
//   state   | meaning
//   IDLE    | waiting for a test_clock strobe
//   SHIFT   | shifting k_q into chain[sel_q], LSB first, WIDTH cycles
//   RESPOND | publish chain_output, raise resp_valid, bump resp_count
module scan_chain_responder
    import scan_resp_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int NUM_CHAINS = NUM_CHAINS_DEF,
    parameter int CNT_W      = CNT_W_DEF
`ifdef FAULT_INJECT_EN
    ,
    parameter int FAULT_CHAIN = 3,
    parameter int FAULT_BIT   = 0,
    parameter int FAULT_VAL   = 1
`endif
) (
    input  logic                  sys_clock,
    input  logic                  sys_reset,
    scan_chain_responder_if.slave bus
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic             w_strobe;
    logic [WIDTH-1:0] w_resp_data;

    state_t           r_state;
    logic [WIDTH-1:0] r_k_q;
    logic [SEL_W-1:0] r_sel_q;
    logic [IDX_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_chain [NUM_CHAINS];
    logic [WIDTH-1:0] r_chain_input;
    logic [WIDTH-1:0] r_chain_output;
    logic             r_resp_valid;
    logic             r_overrun;
    logic [CNT_W-1:0] r_resp_count;

    edge_sync u_tclk_sync (
        .i_clk   (sys_clock),
        .i_rst   (sys_reset),
        .i_async (bus.test_clock),
        .o_pulse (w_strobe)
    );

    always_comb begin
        w_resp_data = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            if (r_sel_q == SEL_W'(i)) begin
                w_resp_data = r_chain[i];
            end
        end
`ifdef FAULT_INJECT_EN
        // Only the published response is corrupted; the chain itself keeps the true pattern.
        if (r_sel_q == SEL_W'(FAULT_CHAIN)) begin
            w_resp_data[FAULT_BIT] = 1'(FAULT_VAL);
        end
`endif
    end

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            r_state        <= IDLE;
            r_k_q          <= '0;
            r_sel_q        <= '0;
            r_cnt          <= '0;
            r_chain_input  <= '0;
            r_chain_output <= '0;
            r_resp_valid   <= 1'b0;
            r_overrun      <= 1'b0;
            r_resp_count   <= '0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                r_chain[i] <= '0;
            end
        end else if (bus.reset) begin
            // Tester reset beats a coincident strobe; count and scan-in echo survive it.
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_chain_output <= '0;
            r_resp_valid   <= 1'b0;
            r_overrun      <= 1'b0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_strobe) begin
                        r_k_q         <= bus.K;
                        r_sel_q       <= bus.mux_decoder_input;
                        r_chain_input <= bus.K;
                        r_resp_valid  <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= sel_valid(bus.mux_decoder_input, NUM_CHAINS) ? SHIFT : RESPOND;
                    end
                end
                SHIFT: begin
                    if (w_strobe) begin
                        r_overrun <= 1'b1;
                    end
                    for (int i = 0; i < NUM_CHAINS; i++) begin
                        if (r_sel_q == SEL_W'(i)) begin
                            r_chain[i] <= {r_k_q[r_cnt], r_chain[i][WIDTH-1:1]};
                        end
                    end
                    if (r_cnt == LAST_IDX) begin
                        r_state <= RESPOND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    if (w_strobe) begin
                        r_overrun <= 1'b1;
                    end
                    r_chain_output <= w_resp_data;
                    r_resp_valid   <= 1'b1;
                    r_resp_count   <= r_resp_count + 1'b1;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.chain_input  = r_chain_input;
    assign bus.chain_output = r_chain_output;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.overrun      = r_overrun;
    assign bus.resp_count   = r_resp_count;

endmodule

// File: tb/tb_scan_chain_responder.sv
// Bench for scan_chain_responder: directed scenarios plus randomized loads against a pattern-level model.
module tb_scan_chain_responder;

    localparam int W  = 6;
    localparam int NC = 22;
    localparam int CW = 16;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    // Reference model: what each chain holds and what the tester should see.
    logic [W-1:0]  m_chain [NC];
    logic [W-1:0]  m_ci;
    logic [W-1:0]  m_co;
    logic          m_ovr;
    logic [CW-1:0] m_count;

    scan_chain_responder_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

    scan_chain_responder dut (
        .sys_clock (clk),
        .sys_reset (rst),
        .bus       (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear_chains();
        for (int i = 0; i < NC; i++) m_chain[i] = '0;
    endtask

    task automatic model_load(input logic [W-1:0] k, input int sel);
        m_ci = k;
        if (sel < NC) begin
            m_chain[sel] = k;
            m_co = m_chain[sel];
        end else begin
            m_co = '0;
        end
`ifdef FAULT_INJECT_EN
        if (sel == 3) m_co[0] = 1'b1;
`endif
        m_count = m_count + 1'b1;
    endtask

    // Edges after the test_clock rise at which resp_valid should first read high.
    function automatic int exp_lat(input int sel);
        return (sel < NC) ? (W + 4) : 4;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise test_clock with a pattern and select; report which edge first shows resp_valid (-1 on timeout).
    task automatic apply_load(input logic [W-1:0] k, input int sel, output int lat);
        lat = -1;
        bus_if.K                 = k;
        bus_if.mux_decoder_input = 5'(sel);
        bus_if.test_clock        = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 4) bus_if.test_clock = 1'b0;
            if (n >= 3 && bus_if.resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus_if.test_clock = 1'b0;
        idle(3);
    endtask

    task automatic pulse_tester_reset();
        bus_if.reset = 1'b1;
        @(negedge clk);
        bus_if.reset = 1'b0;
        model_clear_chains();
        m_co  = '0;
        m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.test_clock = 1'b0;
        bus_if.K = '0;
        bus_if.mux_decoder_input = '0;
        bus_if.reset = 1'b0;
        model_clear_chains();
        m_ci = '0; m_co = '0; m_ovr = 1'b0; m_count = '0;
        idle(3);
        n_vec++; if (bus_if.chain_input !== '0) begin n_err++; $display("FAIL reset_ci: got %0h expected 0", bus_if.chain_input); end
        n_vec++; if (bus_if.chain_output !== '0) begin n_err++; $display("FAIL reset_co: got %0h expected 0", bus_if.chain_output); end
        n_vec++; if (bus_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", bus_if.resp_valid); end
        n_vec++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %0b expected 0", bus_if.overrun); end
        n_vec++; if (bus_if.resp_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus_if.resp_count); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_basic_load();
        int lat;
        apply_load(6'h2A, 5, lat);
        model_load(6'h2A, 5);
        n_vec++; if (lat !== exp_lat(5)) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(5)); end
        n_vec++; if (bus_if.chain_input !== 6'h2A) begin n_err++; $display("FAIL basic_ci: got %0h expected 2a", bus_if.chain_input); end
        n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL basic_co: got %0h expected %0h", bus_if.chain_output, m_co); end
        n_vec++; if (bus_if.resp_count !== 16'd1) begin n_err++; $display("FAIL basic_count: got %0d expected 1", bus_if.resp_count); end
        idle(5);
        n_vec++; if (bus_if.resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %0b expected 1", bus_if.resp_valid); end
        n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL hold_co: got %0h expected %0h", bus_if.chain_output, m_co); end
    endtask

    task automatic test_invalid_select();
        int lat;
        apply_load(6'h3F, 22, lat);
        model_load(6'h3F, 22);
        n_vec++; if (lat !== exp_lat(22)) begin n_err++; $display("FAIL inval_latency: got %0d expected %0d", lat, exp_lat(22)); end
        n_vec++; if (bus_if.chain_output !== '0) begin n_err++; $display("FAIL inval_co: got %0h expected 0", bus_if.chain_output); end
        n_vec++; if (bus_if.chain_input !== 6'h3F) begin n_err++; $display("FAIL inval_ci: got %0h expected 3f", bus_if.chain_input); end
        n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL inval_count: got %0d expected %0d", bus_if.resp_count, m_count); end
        apply_load(6'h11, 31, lat);
        model_load(6'h11, 31);
        n_vec++; if (lat !== exp_lat(31)) begin n_err++; $display("FAIL sel31_latency: got %0d expected %0d", lat, exp_lat(31)); end
        n_vec++; if (bus_if.chain_output !== '0) begin n_err++; $display("FAIL sel31_co: got %0h expected 0", bus_if.chain_output); end
        apply_load(6'h2D, 21, lat);
        model_load(6'h2D, 21);
        n_vec++; if (lat !== exp_lat(21)) begin n_err++; $display("FAIL sel21_latency: got %0d expected %0d", lat, exp_lat(21)); end
        n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL sel21_co: got %0h expected %0h", bus_if.chain_output, m_co); end
    endtask

    task automatic test_retention();
        int lat;
        logic [W-1:0] seq_k [4];
        int           seq_s [4];
        seq_k[0] = 6'h15; seq_s[0] = 2;
        seq_k[1] = 6'h0A; seq_s[1] = 7;
        seq_k[2] = 6'h15; seq_s[2] = 2;
        seq_k[3] = 6'h0A; seq_s[3] = 7;
        for (int i = 0; i < 4; i++) begin
            apply_load(seq_k[i], seq_s[i], lat);
            model_load(seq_k[i], seq_s[i]);
            n_vec++; if (lat !== exp_lat(seq_s[i])) begin n_err++; $display("FAIL ret_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(seq_s[i])); end
            n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL ret_co[%0d]: got %0h expected %0h", i, bus_if.chain_output, m_co); end
        end
        n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL ret_count: got %0d expected %0d", bus_if.resp_count, m_count); end
    endtask

    task automatic test_overrun();
        int lat;
        lat = -1;
        bus_if.K = 6'h27;
        bus_if.mux_decoder_input = 5'd9;
        bus_if.test_clock = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 2) bus_if.test_clock = 1'b0;
            if (n == 3) begin
                bus_if.test_clock = 1'b1;
                bus_if.K = 6'h18;
                bus_if.mux_decoder_input = 5'd12;
            end
            if (n == 6) bus_if.test_clock = 1'b0;
            if (n >= 3 && bus_if.resp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus_if.test_clock = 1'b0;
        idle(4);
        model_load(6'h27, 9);
        m_ovr = 1'b1;
        n_vec++; if (lat !== exp_lat(9)) begin n_err++; $display("FAIL ovr_latency: got %0d expected %0d", lat, exp_lat(9)); end
        n_vec++; if (bus_if.overrun !== m_ovr) begin n_err++; $display("FAIL ovr_flag: got %0b expected 1", bus_if.overrun); end
        n_vec++; if (bus_if.chain_input !== m_ci) begin n_err++; $display("FAIL ovr_ci: got %0h expected %0h", bus_if.chain_input, m_ci); end
        n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL ovr_co: got %0h expected %0h", bus_if.chain_output, m_co); end
        n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL ovr_count: got %0d expected %0d", bus_if.resp_count, m_count); end
        pulse_tester_reset();
        idle(1);
        n_vec++; if (bus_if.overrun !== 1'b0) begin n_err++; $display("FAIL trst_ovr: got %0b expected 0", bus_if.overrun); end
        n_vec++; if (bus_if.chain_output !== '0) begin n_err++; $display("FAIL trst_co: got %0h expected 0", bus_if.chain_output); end
        n_vec++; if (bus_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL trst_valid: got %0b expected 0", bus_if.resp_valid); end
        n_vec++; if (bus_if.chain_input !== m_ci) begin n_err++; $display("FAIL trst_ci: got %0h expected %0h", bus_if.chain_input, m_ci); end
        n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL trst_count: got %0d expected %0d", bus_if.resp_count, m_count); end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bus_if.K = 6'h33;
        bus_if.mux_decoder_input = 5'd4;
        bus_if.test_clock = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_vec++; if (bus_if.chain_input !== '0) begin n_err++; $display("FAIL mid_ci: got %0h expected 0", bus_if.chain_input); end
        n_vec++; if (bus_if.chain_output !== '0) begin n_err++; $display("FAIL mid_co: got %0h expected 0", bus_if.chain_output); end
        n_vec++; if (bus_if.resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b expected 0", bus_if.resp_valid); end
        n_vec++; if (bus_if.resp_count !== '0) begin n_err++; $display("FAIL mid_count: got %0d expected 0", bus_if.resp_count); end
        bus_if.test_clock = 1'b0;
        idle(2);
        rst = 1'b0;
        model_clear_chains();
        m_ci = '0; m_co = '0; m_ovr = 1'b0; m_count = '0;
        idle(3);
        apply_load(6'h1C, 4, lat);
        model_load(6'h1C, 4);
        n_vec++; if (lat !== exp_lat(4)) begin n_err++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, exp_lat(4)); end
        n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL post_rst_co: got %0h expected %0h", bus_if.chain_output, m_co); end
        n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL post_rst_count: got %0d expected %0d", bus_if.resp_count, m_count); end
    endtask

    task automatic test_random();
        int lat;
        int sel;
        logic [W-1:0] k;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                pulse_tester_reset();
                idle(1);
                n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL rnd_trst_co[%0d]: got %0h expected %0h", i, bus_if.chain_output, m_co); end
            end
            k   = W'($urandom_range(0, 63));
            sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(22, 31)) : int'($urandom_range(0, 21));
            apply_load(k, sel, lat);
            model_load(k, sel);
            n_vec++; if (lat !== exp_lat(sel)) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d sel=%0d", i, lat, exp_lat(sel), sel); end
            n_vec++; if (bus_if.chain_input !== m_ci) begin n_err++; $display("FAIL rnd_ci[%0d]: got %0h expected %0h", i, bus_if.chain_input, m_ci); end
            n_vec++; if (bus_if.chain_output !== m_co) begin n_err++; $display("FAIL rnd_co[%0d]: got %0h expected %0h sel=%0d", i, bus_if.chain_output, m_co, sel); end
            n_vec++; if (bus_if.resp_count !== m_count) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, bus_if.resp_count, m_count); end
            n_vec++; if (bus_if.overrun !== m_ovr) begin n_err++; $display("FAIL rnd_ovr[%0d]: got %0b expected %0b", i, bus_if.overrun, m_ovr); end
        end
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault();
        int lat;
        apply_load(6'h00, 3, lat);
        model_load(6'h00, 3);
        n_vec++; if (bus_if.chain_output !== 6'h01) begin n_err++; $display("FAIL fault_sel3: got %0h expected 01", bus_if.chain_output); end
        apply_load(6'h00, 4, lat);
        model_load(6'h00, 4);
        n_vec++; if (bus_if.chain_output !== 6'h00) begin n_err++; $display("FAIL fault_sel4: got %0h expected 00", bus_if.chain_output); end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        test_reset();
        test_basic_load();
        test_invalid_select();
        test_retention();
        test_overrun();
        test_reset_mid_shift();
`ifdef FAULT_INJECT_EN
        test_fault();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
